mcpu_soc_ltcrd_arb: RTL and testbench

Two-requester arbiter for the SoC's single LTC read port (128-bit beats, 8 beats per 1024-bit line). Sits between the LTC and its read clients: the video scanout engine (real-time, high priority) and a second general-purpose reader (DMA/blitter, low priority). Grants one line read at a time, forwards the request with LTC stall handling, and routes the returned beats to the owning requester. Optional anti-starvation for the low-priority port.

---
 rtl/mcpu_soc_ltcrd_pkg.sv | 24 ++
 rtl/mcpu_soc_ltcrd_arb.sv | 134 +++++++++++++
 tb/tb_mcpu_soc_ltcrd_arb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mcpu_soc_ltcrd_pkg.sv
// ---------------------------------------------------------------------------
// mcpu_soc_ltcrd_pkg : shared types for the LTC read-port arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mcpu_soc_ltcrd_pkg;

  localparam int LINE_AW = 22;
  localparam int BEAT_W  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/mcpu_soc_ltcrd_arb.sv
// ---------------------------------------------------------------------------
// mcpu_soc_ltcrd_arb : two-port (video/dma) line-read arbiter for the LTC.
// Define MCPU_LTCRD_ARB_STARVE_EN for dma anti-starvation. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mcpu_soc_ltcrd_arb
  import mcpu_soc_ltcrd_pkg::*;
#(
  parameter int BEATS      = 8,
  parameter int STARVE_MAX = 64
) (
  input  logic                clkrst_core_clk,
  input  logic                clkrst_core_rst,
  input  logic                vid_re,
  input  logic [28:7]         vid_addr,
  output logic                vid_stall,
  output logic                vid_rvalid,
  output logic [BEAT_W-1:0]   vid_rdata,
  input  logic                dma_re,
  input  logic [28:7]         dma_addr,
  output logic                dma_stall,
  output logic                dma_rvalid,
  output logic [BEAT_W-1:0]   dma_rdata,
  output logic                ltc_re,
  output logic [28:7]         ltc_addr,
  input  logic                ltc_stall,
  input  logic                ltc_rvalid,
  input  logic [BEAT_W-1:0]   ltc_rdata,
  output logic                err_spurious
);

  localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e              state_q;
  owner_e              owner_q;
  logic [LINE_AW-1:0]  addr_q;
  logic [BCW-1:0]      beat_cnt_q;
  logic                err_q;

  logic dma_force;
  logic grant_vid;
  logic grant_dma;
  logic in_idle;
  logic in_data;
  logic last_beat;

  assign in_idle   = (state_q == IDLE) & ~clkrst_core_rst;
  assign in_data   = (state_q == DATA) & ~clkrst_core_rst;
  assign last_beat = (beat_cnt_q == BCW'(BEATS - 1));

`ifdef MCPU_LTCRD_ARB_STARVE_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);
  logic [SCW-1:0] starve_q;

  assign dma_force = dma_re & (starve_q >= SCW'(STARVE_MAX));

  // Saturates at STARVE_MAX; only the >= threshold matters past that.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      starve_q <= '0;
    end else if (grant_dma) begin
      starve_q <= '0;
    end else if (dma_re && (starve_q < SCW'(STARVE_MAX))) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign dma_force = 1'b0;

  // STARVE_MAX stays on the interface so both builds share one parameter list.
  if (STARVE_MAX < 1) begin : g_starve_max_unused
  end
`endif

  assign grant_dma = in_idle & dma_re & (~vid_re | dma_force);
  assign grant_vid = in_idle & vid_re & ~grant_dma;

  assign vid_stall  = ~grant_vid;
  assign dma_stall  = ~grant_dma;
  assign ltc_re     = (state_q == ISSUE);
  assign ltc_addr   = addr_q;
  assign vid_rvalid = ltc_rvalid & in_data & (owner_q == OWN_VID);
  assign dma_rvalid = ltc_rvalid & in_data & (owner_q == OWN_DMA);
  assign vid_rdata  = ltc_rdata;
  assign dma_rdata  = ltc_rdata;
  assign err_spurious = err_q;

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_VID;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // Any beat outside DATA has no owner and is discarded.
      if (ltc_rvalid && (state_q != DATA)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (grant_dma) begin
            owner_q <= OWN_DMA;
            addr_q  <= dma_addr;
            state_q <= ISSUE;
          end else if (grant_vid) begin
            owner_q <= OWN_VID;
            addr_q  <= vid_addr;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!ltc_stall) begin
            beat_cnt_q <= '0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (ltc_rvalid) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (last_beat) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mcpu_soc_ltcrd_arb.sv
// ---------------------------------------------------------------------------
// tb_mcpu_soc_ltcrd_arb : randomized bench with a transaction-level model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mcpu_soc_ltcrd_arb;

  localparam int BEATS = 8;
  localparam int SMAX  = 4;

`ifdef MCPU_LTCRD_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         vid_re, dma_re, ltc_stall, ltc_rvalid;
  logic [21:0]  vid_addr, dma_addr;
  logic [127:0] ltc_rdata;
  logic         vid_stall, vid_rvalid, dma_stall, dma_rvalid;
  logic [127:0] vid_rdata, dma_rdata;
  logic         ltc_re, err_spurious;
  logic [21:0]  ltc_addr;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: one outstanding line read, described as a transaction record.
  bit        m_busy, m_acc, m_own_dma, m_err;
  logic [21:0] m_addr;
  int        m_left, m_starve;
  // Requester side: a request stays up until it is granted.
  bit          vp, dp;
  logic [21:0] va, da;

  always #5 clk = ~clk;

  mcpu_soc_ltcrd_arb #(.BEATS(BEATS), .STARVE_MAX(SMAX)) u_dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .vid_re          (vid_re),
    .vid_addr        (vid_addr),
    .vid_stall       (vid_stall),
    .vid_rvalid      (vid_rvalid),
    .vid_rdata       (vid_rdata),
    .dma_re          (dma_re),
    .dma_addr        (dma_addr),
    .dma_stall       (dma_stall),
    .dma_rvalid      (dma_rvalid),
    .dma_rdata       (dma_rdata),
    .ltc_re          (ltc_re),
    .ltc_addr        (ltc_addr),
    .ltc_stall       (ltc_stall),
    .ltc_rvalid      (ltc_rvalid),
    .ltc_rdata       (ltc_rdata),
    .err_spurious    (err_spurious)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_own_dma = 0; m_err = 0;
    m_addr = '0; m_left = 0; m_starve = 0;
    vp = 0; dp = 0; va = '0; da = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    vid_re = 0; dma_re = 0; ltc_stall = 0; ltc_rvalid = 0;
    vid_addr = '0; dma_addr = '0; ltc_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive random inputs, check every output, advance the model.
  task automatic step(input int pv, input int pd, input int pst, input int prv, input int pspur);
    bit gv, gd, force_d, data;
    @(posedge clk); #1;
    if (!vp && roll(pv)) begin vp = 1; va = 22'($urandom); end
    if (!dp && roll(pd)) begin dp = 1; da = 22'($urandom); end
    vid_re = vp; vid_addr = va;
    dma_re = dp; dma_addr = da;
    ltc_stall  = roll(pst);
    data       = m_busy && m_acc;
    ltc_rvalid = data ? roll(prv) : roll(pspur);
    ltc_rdata  = {$urandom, $urandom, $urandom, $urandom};
    #1;
    gv = 0; gd = 0;
    if (!m_busy) begin
      force_d = STARVE_ON && dp && (m_starve >= SMAX);
      gd = dp && (!vp || force_d);
      gv = vp && !gd;
    end
    check_val("vid_stall",  vid_stall,  !gv);
    check_val("dma_stall",  dma_stall,  !gd);
    check_val("ltc_re",     ltc_re,     m_busy && !m_acc);
    check_val("ltc_addr",   ltc_addr,   m_addr);
    check_val("vid_rvalid", vid_rvalid, data && !m_own_dma && ltc_rvalid);
    check_val("dma_rvalid", dma_rvalid, data && m_own_dma && ltc_rvalid);
    check_val("vid_rdata",  vid_rdata,  ltc_rdata);
    check_val("dma_rdata",  dma_rdata,  ltc_rdata);
    check_val("err_spur",   err_spurious, m_err);

    if (ltc_rvalid && !data) m_err = 1;
    if (STARVE_ON) begin
      if (gd) m_starve = 0;
      else if (dp) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
    end
    if (gv || gd) begin
      m_busy = 1; m_acc = 0; m_own_dma = gd; m_left = BEATS;
      m_addr = gd ? da : va;
      if (gd) dp = 0; else vp = 0;
    end else if (m_busy && !m_acc && !ltc_stall) begin
      m_acc = 1;
    end else if (data && ltc_rvalid) begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_acc = 0; end
    end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0);
    // Mixed traffic, no spurious beats.
    repeat (400) step(30, 30, 30, 60, 0);
    // Video always requesting: exercises priority and the starvation path.
    repeat (300) step(100, 100, 20, 80, 0);
    // Heavy LTC stalls.
    repeat (200) step(40, 40, 85, 50, 0);
    // Resets in the middle of traffic, then stray beats arriving afterwards.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(10, 40)) step(60, 60, 20, 90, 0);
      do_reset();
      repeat (20) step(30, 30, 30, 60, 30);
    end
    do_reset();
    repeat (300) step(50, 50, 50, 50, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
